instr_mem_loader: RTL and testbench

Parametrised, byte-organised instruction memory with an integrated FIFO loader engine.
- A load command streams N instruction words from the FIFO, via a valid/ready handshake, into a programmable base address.
- The PC side reads through a registered, fault-checked fetch port.
- Replaces the direct single-word write port with a sequenced, bounds-checked, endian-selectable loader for the control unit.

---
 rtl/instr_mem_loader.sv | 161 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-organised instruction memory with a FIFO-fed loader engine and a
// registered, fault-checked fetch port.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for load_start; commands are validated here
// LOAD   | accepting words from the FIFO (s_ready high)
// DONE   | one-cycle load_done pulse, then back to IDLE
module instr_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH  = 1024,
    parameter bit BIG_ENDIAN = 1'b1,
    localparam int NB = DATA_WIDTH / BYTE_WIDTH,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int LW = $clog2(MEM_DEPTH / NB) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [AW-1:0]         load_base,
    input  logic [LW-1:0]         load_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_fault
);

    localparam int CW = AW + LW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [BYTE_WIDTH-1:0] mem [MEM_DEPTH];

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [LW-1:0]         len_q, len_d;
    logic                  err_q, err_d;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_fault_q, rd_fault_d;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  fetch_bad;

    // Command end address is computed wide enough that it can never wrap.
    logic [CW-1:0]         cmd_end;
    logic                  cmd_ok;

    assign cmd_end = CW'(load_base) + (CW'(load_len) * CW'(NB));
    assign cmd_ok  = ((load_base & AW'(NB - 1)) == '0) && (cmd_end <= CW'(MEM_DEPTH));

    assign s_ready   = (state_q == S_LOAD);
    assign load_busy = (state_q == S_LOAD);
    assign load_done = (state_q == S_DONE);
    assign load_err  = err_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_fault  = rd_fault_q;

    // Loader FSM next-state, pointer and counter logic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (cmd_ok) begin
                        err_d    = 1'b0;
                        len_d    = load_len;
                        wr_ptr_d = load_base;
                        cnt_d    = '0;
                        state_d  = (load_len == '0) ? S_DONE : S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(NB);
                    cnt_d    = cnt_q + LW'(1);
                    if (cnt_q == len_q - LW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Fetch: assemble the addressed word and decide whether the fetch faults.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NB; i++) begin
            rd_word[(BIG_ENDIAN ? (NB - 1 - i) : i) * BYTE_WIDTH +: BYTE_WIDTH] =
                mem[rd_addr[AW-1:0] + AW'(i)];
        end
        fetch_bad = ((rd_addr & ADDR_WIDTH'(NB - 1)) != '0) ||
                    ({1'b0, rd_addr} >= (ADDR_WIDTH + 1)'(MEM_DEPTH)) ||
                    (state_q == S_LOAD);
        rd_valid_d = rd_en;
        rd_fault_d = rd_en && fetch_bad;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = fetch_bad ? '0 : rd_word;
        end
    end

    // Control and fetch registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_fault_q <= rd_fault_d;
        end
    end

    // Memory byte writes; contents survive reset, and a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                mem[wr_ptr_q + AW'(i)] <=
                    s_data[(BIG_ENDIAN ? (NB - 1 - i) : i) * BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench: a big-endian and a little-endian instance share stimulus
// and are compared against a word-level memory model.
module tb_instr_mem_loader;

    localparam int AW = 10;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n, load_start, s_valid, rd_en;
    logic [AW-1:0] load_base;
    logic [LW-1:0] load_len;
    logic [31:0]   s_data, rd_addr;

    logic s_ready_b, load_busy_b, load_done_b, load_err_b, rd_valid_b, rd_fault_b;
    logic s_ready_l, load_busy_l, load_done_l, load_err_l, rd_valid_l, rd_fault_l;
    logic [31:0] rd_data_b, rd_data_l;

    always #5 clk = ~clk;

    instr_mem_loader #(.BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
        .load_busy(load_busy_b), .load_done(load_done_b), .load_err(load_err_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .rd_fault(rd_fault_b));

    instr_mem_loader #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_l),
        .load_busy(load_busy_l), .load_done(load_done_l), .load_err(load_err_l),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_l), .rd_valid(rd_valid_l),
        .rd_fault(rd_fault_l));

    // Reference model: memory as an array of words, addressed by byte address / 4.
    logic [31:0] wmem [256];
    logic [31:0] words [$];
    int total = 0;
    int bad   = 0;

    typedef struct { int base; int len; bit ok; string nm; } cmd_t;
    typedef struct { logic [31:0] addr; bit fault; string nm; } fvec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_ctrl(input string nm, input bit rdy, input bit busy, input bit done, input bit err);
        chk(nm, {s_ready_b, load_busy_b, load_done_b, load_err_b,
                 s_ready_l, load_busy_l, load_done_l, load_err_l},
                {rdy, busy, done, err, rdy, busy, done, err});
    endtask

    function automatic bit cmd_legal(input int base, input int len);
        return (base % 4 == 0) && (base + len * 4 <= 1024);
    endfunction

    // vpct: percentage of cycles with s_valid high; negative means strict 1-0-1-0.
    task automatic do_load(input int base, input int len, input int vpct, input bit poke,
                           input bit exp_ok, input string nm);
        int idx;
        int cyc;
        load_start = 1'b1;
        load_base  = AW'(base);
        load_len   = LW'(len);
        step();
        load_start = 1'b0;
        if (!exp_ok) begin
            chk_ctrl({nm, "_reject"}, 0, 0, 0, 1);
            return;
        end
        if (len == 0) begin
            chk_ctrl({nm, "_len0_done"}, 0, 0, 1, 0);
            step();
            chk_ctrl({nm, "_len0_idle"}, 0, 0, 0, 0);
            return;
        end
        chk_ctrl({nm, "_start"}, 1, 1, 0, 0);
        idx = 0;
        cyc = 0;
        while (idx < len) begin
            s_valid = (vpct < 0) ? (cyc % 2 == 0) : ($urandom_range(0, 99) < vpct);
            s_data  = (s_valid && idx < words.size()) ? words[idx] : $urandom;
            if (poke) begin
                load_start = 1'b1;
                load_base  = AW'(2);
                load_len   = LW'(1);
            end
            step();
            if (s_valid) begin
                wmem[(base / 4) + idx] = s_data;
                idx++;
            end
            cyc++;
            if (idx < len) chk_ctrl({nm, "_busy"}, 1, 1, 0, 0);
            else           chk_ctrl({nm, "_done"}, 0, 0, 1, 0);
            if (cyc > 3000) begin
                chk({nm, "_timeout"}, 128'd1, 128'd0);
                break;
            end
        end
        s_valid = 1'b0;
        step();
        load_start = 1'b0;
        chk_ctrl({nm, "_end"}, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] a, input bit expf, input string nm);
        logic [31:0] expd;
        expd    = expf ? 32'h0 : wmem[a[9:2]];
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        rd_addr = $urandom;
        chk(nm, {rd_valid_b, rd_fault_b, rd_data_b, rd_valid_l, rd_fault_l, rd_data_l},
                {1'b1, expf, expd, 1'b1, expf, expd});
        step();
        chk({nm, "_hold"}, {rd_valid_b, rd_data_b, rd_valid_l, rd_data_l},
                           {1'b0, expd, 1'b0, expd});
    endtask

    function automatic bit fault_of(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd1024);
    endfunction

    initial begin
        cmd_t  cmds [4];
        fvec_t fv   [6];
        int    base, len;
        logic [31:0] a;

        cmds[0] = '{base: 'h002, len: 1, ok: 1'b0, nm: "cmd_misalign"};
        cmds[1] = '{base: 'h3FC, len: 2, ok: 1'b0, nm: "cmd_overrun"};
        cmds[2] = '{base: 'h3FC, len: 1, ok: 1'b1, nm: "cmd_lastword"};
        cmds[3] = '{base: 'h040, len: 0, ok: 1'b1, nm: "cmd_len0"};
        fv[0] = '{addr: 32'h0000_0001, fault: 1'b1, nm: "f_misalign"};
        fv[1] = '{addr: 32'h0000_0400, fault: 1'b1, nm: "f_depth"};
        fv[2] = '{addr: 32'h8000_0400, fault: 1'b1, nm: "f_highbits"};
        fv[3] = '{addr: 32'h8000_0000, fault: 1'b1, nm: "f_high_only"};
        fv[4] = '{addr: 32'h0000_03FC, fault: 1'b0, nm: "f_top_word"};
        fv[5] = '{addr: 32'h0000_0004, fault: 1'b0, nm: "f_word1"};

        rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
        s_valid = 1'b0; s_data = '0; rd_en = 1'b0; rd_addr = '0;
        for (int i = 0; i < 256; i++) wmem[i] = 32'h0;
        step();
        step();
        chk_ctrl("reset_ctrl", 0, 0, 0, 0);
        chk("reset_rd", {rd_valid_b, rd_fault_b, rd_data_b, rd_valid_l, rd_fault_l, rd_data_l}, '0);
        rst_n = 1'b1;

        // Known-zero contents for the model.
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back(32'h0);
        do_load(0, 256, 100, 1'b0, 1'b1, "fill");

        words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8133};
        do_load(0, 3, 100, 1'b0, 1'b1, "tp1");
        fetch(32'h000, 1'b0, "tp1_f0");
        fetch(32'h004, 1'b0, "tp1_f4");
        fetch(32'h008, 1'b0, "tp1_f8");

        words = '{32'hAABB_CCDD};
        do_load('h010, 1, 100, 1'b0, 1'b1, "endian");
        chk("be_byte10", {120'd0, u_be.mem[16]}, {120'd0, 8'hAA});
        chk("be_byte13", {120'd0, u_be.mem[19]}, {120'd0, 8'hDD});
        chk("le_byte10", {120'd0, u_le.mem[16]}, {120'd0, 8'hDD});
        fetch(32'h010, 1'b0, "endian_fetch");

        words = '{32'h1111_1111, 32'h2222_2222};
        do_load('h020, 2, -1, 1'b1, 1'b1, "toggle");
        fetch(32'h020, 1'b0, "tog_f0");
        fetch(32'h024, 1'b0, "tog_f1");
        fetch(32'h028, 1'b0, "tog_f2_untouched");

        for (int i = 0; i < 4; i++) begin
            words = '{32'hC0DE_0000 + i};
            do_load(cmds[i].base, cmds[i].len, 100, 1'b0, cmds[i].ok, cmds[i].nm);
        end
        fetch(32'h3FC, 1'b0, "cmd_lastword_fetch");
        fetch(32'h040, 1'b0, "cmd_len0_unchanged");

        for (int i = 0; i < 6; i++) fetch(fv[i].addr, fv[i].fault, fv[i].nm);

        // Fetch issued while the loader is in LOAD must fault.
        load_start = 1'b1; load_base = AW'('h080); load_len = LW'(1);
        step();
        load_start = 1'b0;
        rd_en = 1'b1; rd_addr = 32'h0;
        step();
        rd_en = 1'b0;
        chk("f_during_load", {rd_valid_b, rd_fault_b, rd_data_b, rd_valid_l, rd_fault_l, rd_data_l},
                             {1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0});
        s_valid = 1'b1; s_data = 32'h5555_AAAA;
        step();
        wmem['h080 / 4] = 32'h5555_AAAA;
        s_valid = 1'b0;
        chk_ctrl("fdl_done", 0, 0, 1, 0);
        step();
        fetch(32'h080, 1'b0, "fdl_after");

        // Reset in the middle of a 4-word load, after two transfers.
        load_start = 1'b1; load_base = AW'('h100); load_len = LW'(4);
        step();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 32'hA000_0001 + i;
            step();
            wmem[('h100 / 4) + i] = s_data;
        end
        s_data = 32'hDEAD_BEEF;
        rst_n  = 1'b0;
        step();
        chk_ctrl("rst_mid_ctrl", 0, 0, 0, 0);
        chk("rst_mid_rd", {rd_valid_b, rd_fault_b, rd_data_b, rd_valid_l, rd_fault_l, rd_data_l}, '0);
        rst_n = 1'b1; s_valid = 1'b0;
        step();
        chk_ctrl("rst_mid_idle", 0, 0, 0, 0);
        fetch(32'h100, 1'b0, "rst_w1");
        fetch(32'h104, 1'b0, "rst_w2");
        fetch(32'h108, 1'b0, "rst_w3_zero");
        fetch(32'h10C, 1'b0, "rst_w4_zero");

        // Randomised loads and fetches against the model.
        for (int it = 0; it < 30; it++) begin
            base = $urandom_range(0, 255) * 4;
            if ($urandom_range(0, 7) == 0) base = base + $urandom_range(1, 3);
            len = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) base = 1024 - 4 * $urandom_range(0, 4);
            if (base > 1023) base = 1020;
            words.delete();
            do_load(base, len, 70, 1'(($urandom & 1)), cmd_legal(base, len), "rnd_load");
            for (int k = 0; k < 4; k++) begin
                a = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 255) * 4);
                fetch(a, fault_of(a), "rnd_fetch");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
